neuron_weight_sequencer: RTL and testbench

NEURON_WEIGHT_SEQUENCER -- requirements
Module: neuron_weight_sequencer

---
 rtl/neuron_weight_sequencer.sv | 80 ++++++++
 tb/tb_neuron_weight_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/neuron_weight_sequencer.sv
// neuron_weight_sequencer: pairs incoming samples with weights read from memory, one neuron pass at a time.
// Optional macro NWS_DROP_COUNT_EN adds a saturating counter of samples refused while in_ready is low.
module neuron_weight_sequencer #(
    parameter int NUMWEIGHT = 4,
    parameter int ADDRESSWIDTH = $clog2(NUMWEIGHT),
    parameter int DATAWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATAWIDTH-1:0]    in_data,
    output logic                    in_ready,
    input  logic                    restart,
    output logic                    mem_ren,
    output logic [ADDRESSWIDTH-1:0] mem_radd,
    input  logic [DATAWIDTH-1:0]    mem_wout,
    output logic                    pair_valid,
    output logic [DATAWIDTH-1:0]    pair_x,
    output logic [DATAWIDTH-1:0]    pair_w,
    output logic                    pair_last,
    output logic                    done,
`ifdef NWS_DROP_COUNT_EN
    output logic [7:0]              drop_cnt,
`endif
    input  logic                    done_ack
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [ADDRESSWIDTH-1:0] LAST = ADDRESSWIDTH'(NUMWEIGHT - 1);

    state_t                  state;
    logic [ADDRESSWIDTH-1:0] cnt;
    logic                    accept;
    logic                    at_last;

    assign in_ready = (state != HOLD) && !restart;
    assign accept   = in_valid && in_ready;
    assign at_last  = cnt == LAST;
    assign mem_ren  = accept;
    assign mem_radd = cnt;
    assign pair_w   = mem_wout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            pair_x     <= '0;
            done       <= 1'b0;
        end else begin
            pair_valid <= accept;
            pair_last  <= accept && at_last;
            if (accept)
                pair_x <= in_data;
            if (restart) begin
                state <= IDLE;
                cnt   <= '0;
                done  <= 1'b0;
            end else if (accept) begin
                cnt   <= at_last ? '0 : cnt + 1'b1;
                state <= at_last ? HOLD : RUN;
            end else if (state == HOLD && done && done_ack) begin
                state <= IDLE;
                done  <= 1'b0;
            end else if (state == HOLD && pair_last) begin
                // done follows the last pair by one cycle
                done <= 1'b1;
            end
        end
    end

`ifdef NWS_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (in_valid && !in_ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// tb_neuron_weight_sequencer: directed and random checks of neuron_weight_sequencer against a pass-level model.
module tb_neuron_weight_sequencer;
    localparam int N = 4;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [15:0] in_data = 0;
    logic        in_ready;
    logic        restart = 0;
    logic        mem_ren;
    logic [1:0]  mem_radd;
    logic [15:0] mem_wout = 0;
    logic        pair_valid;
    logic [15:0] pair_x;
    logic [15:0] pair_w;
    logic        pair_last;
    logic        done;
    logic        done_ack = 0;
`ifdef NWS_DROP_COUNT_EN
    logic [7:0]  drop_cnt;
`endif

    neuron_weight_sequencer #(.NUMWEIGHT(N), .DATAWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_ren(mem_ren), .mem_radd(mem_radd),
        .mem_wout(mem_wout), .pair_valid(pair_valid), .pair_x(pair_x), .pair_w(pair_w),
        .pair_last(pair_last), .done(done),
`ifdef NWS_DROP_COUNT_EN
        .drop_cnt(drop_cnt),
`endif
        .done_ack(done_ack)
    );

    always #5 clk = ~clk;

    logic [15:0] wmem [N];
    always @(posedge clk) if (mem_ren) mem_wout <= wmem[mem_radd];

    int vectors = 0;
    int miscompares = 0;
    // model: samples taken in this pass, whether the pass is waiting for ack, cycles spent waiting
    int k = 0;
    bit waiting = 0;
    int hold_age = 0;
    int drops = 0;
    logic [15:0] px = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; waiting = 0; hold_age = 0; drops = 0; px = 0;
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit rs, input bit ack);
        bit acc, ex_last;
        int a;
        @(negedge clk);
        in_valid = v; in_data = d; restart = rs; done_ack = ack;
        #1;
        chk("in_ready", in_ready, !waiting && !rs);
        acc = v && !waiting && !rs;
        if (v && !acc) drops++;
        chk("mem_ren", mem_ren, acc);
        if (acc) chk("mem_radd", mem_radd, k);
        a = k;
        ex_last = acc && (k == N - 1);
        @(posedge clk);
        #1;
        if (acc) px = d;
        if (rs) begin
            k = 0; waiting = 0; hold_age = 0;
        end else if (acc) begin
            k++;
            if (k == N) begin k = 0; waiting = 1; hold_age = 0; end
        end else if (waiting) begin
            if (hold_age >= 1 && ack) waiting = 0;
            else hold_age++;
        end
        chk("pair_valid", pair_valid, acc);
        chk("pair_last", pair_last, ex_last);
        chk("pair_x", pair_x, px);
        chk("done", done, waiting && hold_age >= 1);
        if (acc) chk("pair_w", pair_w, wmem[a]);
`ifdef NWS_DROP_COUNT_EN
        chk("drop_cnt", drop_cnt, drops > 255 ? 255 : drops);
`endif
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 0; restart = 0; done_ack = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_pair_valid", pair_valid, 0);
        chk("rst_pair_last", pair_last, 0);
        chk("rst_done", done, 0);
        chk("rst_pair_x", pair_x, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_ren", mem_ren, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) wmem[i] = 16'($urandom);
        #12;
        chk("rst_pair_valid", pair_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pair_x", pair_x, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_ren", mem_ren, 0);
        @(negedge clk) rst_n = 1;
        // full pass 10,-3,7,2
        step(1, 16'd10, 0, 0);
        step(1, -16'sd3, 0, 0);
        step(1, 16'd7, 0, 0);
        step(1, 16'd2, 0, 0);
        // refused samples while waiting for ack
        step(1, 16'd99, 0, 0);
        step(1, 16'd98, 0, 0);
        step(1, 16'd97, 0, 0);
        step(0, 16'd0, 0, 1);
        step(1, 16'd5, 0, 0);
        // restart abandons the pass after two samples
        step(1, 16'd6, 0, 0);
        step(0, 16'd0, 1, 0);
        step(1, 16'd11, 0, 0);
        // restart together with a valid sample
        step(1, 16'd12, 1, 0);
        step(1, 16'd13, 0, 0);
        step(1, 16'd14, 0, 0);
        // asynchronous reset mid-pass
        async_reset();
        step(1, 16'd20, 0, 0);
        step(1, 16'd21, 0, 0);
        // gapped input
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 16'(100 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 16'd0, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
